// File: rtl/row_seq_pkg.sv
// row_seq_pkg: shared width helpers, next-state select enum and default parameters for row_index_sequencer
package row_seq_pkg;
  localparam int DEF_ROWS_PER_QUAD = 6;
  localparam int DEF_NUM_QUADS = 2;
  localparam int DEF_REWIND = 2;
  localparam int DEF_NUM_LAYERS = 4;
  typedef enum logic [1:0] {SEL_BASE, SEL_REWIND, SEL_INC, SEL_HOLD} sel_e;
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/row_index_sequencer_layer_counter.sv
// layer_counter: wrapping layer count (clock, reset_n, clear, inc in; layer_index, last_layer out)
module layer_counter
  import row_seq_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  localparam int LYR_W = clog2w(NUM_LAYERS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [LYR_W-1:0] layer_index,
  output logic             last_layer
);
  localparam logic [LYR_W-1:0] LAST = LYR_W'(NUM_LAYERS - 1);
  assign last_layer = layer_index == LAST;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) layer_index <= '0;
    else if (clear) layer_index <= '0;
    else if (inc) layer_index <= last_layer ? '0 : layer_index + LYR_W'(1);
endmodule

// File: rtl/row_index_sequencer.sv
// row_index_sequencer: quadrant row-index sequencer (clock, reset_n, clear, en, new_row, new_vector, new_quadrant_row, quadrant_sel in; row_index, new_layer, seq_err, layer_index, last_layer out; layer counter built only with ROW_INDEX_SEQUENCER_LAYER_COUNT_EN)
module row_index_sequencer
  import row_seq_pkg::*;
#(
  parameter int ROWS_PER_QUAD = DEF_ROWS_PER_QUAD,
  parameter int NUM_QUADS = DEF_NUM_QUADS,
  parameter int REWIND = DEF_REWIND,
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  localparam int IDX_W = clog2w(ROWS_PER_QUAD * NUM_QUADS),
  localparam int QSEL_W = clog2w(NUM_QUADS),
  localparam int LYR_W = clog2w(NUM_LAYERS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              en,
  input  logic              new_row,
  input  logic              new_vector,
  input  logic              new_quadrant_row,
  input  logic [QSEL_W-1:0] quadrant_sel,
  output logic [IDX_W-1:0]  row_index,
  output logic              new_layer,
  output logic              seq_err,
  output logic [LYR_W-1:0]  layer_index,
  output logic              last_layer
);
  typedef logic [IDX_W:0] w_t;
  localparam w_t RPQ = w_t'(ROWS_PER_QUAD);
  localparam w_t LAST = w_t'(ROWS_PER_QUAD - 1);
  localparam w_t RW = w_t'(REWIND);
  localparam w_t QMAX = w_t'(NUM_QUADS - 1);
  w_t rx, qs, qc, base, riq, qstart, nw;
  sel_e sel;
  logic restart, incr, under, over, err_d;
  logic [IDX_W-1:0] row_next;
  always_comb begin
    rx = {1'b0, row_index};
    qs = w_t'(quadrant_sel);
    qc = qs > QMAX ? QMAX : qs;
    base = qc * RPQ;
    riq = rx % RPQ;
    qstart = rx - riq;
    new_layer = new_quadrant_row && riq == LAST;
    restart = new_vector && !new_quadrant_row;
    incr = (new_row || new_quadrant_row) && en;
    sel = (clear || new_layer) ? SEL_BASE : restart ? SEL_REWIND : incr ? SEL_INC : SEL_HOLD;
    under = rx < qstart + RW;
    over = riq == LAST;
    nw = sel == SEL_BASE ? base :
         sel == SEL_REWIND ? (under ? qstart : rx - RW) :
         (sel == SEL_INC && !over) ? rx + w_t'(1) : rx;
    row_next = IDX_W'(nw);
    err_d = (sel == SEL_REWIND && under) || (sel == SEL_INC && over);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      row_index <= '0;
      seq_err <= 1'b0;
    end else begin
      row_index <= row_next;
      seq_err <= err_d;
    end
`ifdef ROW_INDEX_SEQUENCER_LAYER_COUNT_EN
  layer_counter #(.NUM_LAYERS(NUM_LAYERS)) u_layer_counter (
    .clock(clock),
    .reset_n(reset_n),
    .clear(clear),
    .inc(new_layer),
    .layer_index(layer_index),
    .last_layer(last_layer)
  );
`else
  assign layer_index = '0;
  assign last_layer = 1'b0;
`endif
endmodule

// File: tb/tb_row_index_sequencer.sv
// tb_row_index_sequencer: table, hand-written and random checks of row_index_sequencer against a behavioural model
module tb_row_index_sequencer;
  localparam int R = 6;
  localparam int Q = 2;
  localparam int RW = 2;
  localparam int L = 4;
  localparam int QSEL_W = 1;
  localparam int IDX_W = 4;
  localparam int LYR_W = 2;
  logic clock = 1'b0;
  logic reset_n, clear, en, new_row, new_vector, new_quadrant_row;
  logic [QSEL_W-1:0] quadrant_sel;
  logic [IDX_W-1:0] row_index;
  logic new_layer, seq_err, last_layer;
  logic [LYR_W-1:0] layer_index;
  int n_checks = 0;
  int n_fail = 0;
  int m_row = 0;
  int m_lay = 0;
  int last_nl = 0;
  typedef struct {
    logic c, e, nr, nv, nq;
    int qs, row, err, nl;
  } vec_t;
  vec_t tbl[$];
  always #5 clock = ~clock;
  row_index_sequencer dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .en(en), .new_row(new_row),
    .new_vector(new_vector), .new_quadrant_row(new_quadrant_row), .quadrant_sel(quadrant_sel),
    .row_index(row_index), .new_layer(new_layer), .seq_err(seq_err),
    .layer_index(layer_index), .last_layer(last_layer)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int exp_last();
`ifdef ROW_INDEX_SEQUENCER_LAYER_COUNT_EN
    return (m_lay == L - 1) ? 1 : 0;
`else
    return 0;
`endif
  endfunction
  task automatic step(input logic c, e, nr, nv, nq, input int qs);
    int q, off, start, nxt, err, nl;
    clear = c; en = e; new_row = nr; new_vector = nv; new_quadrant_row = nq;
    quadrant_sel = QSEL_W'(qs);
    #1;
    q = m_row / R;
    off = m_row % R;
    start = q * R;
    nl = (nq && off == R - 1) ? 1 : 0;
    err = 0;
    nxt = m_row;
    if (c || nl) nxt = ((qs >= Q) ? Q - 1 : qs) * R;
    else if (nv && !nq) begin
      if (m_row - RW < start) begin nxt = start; err = 1; end
      else nxt = m_row - RW;
    end else if ((nr || nq) && e) begin
      if (off == R - 1) err = 1;
      else nxt = m_row + 1;
    end
    chk("new_layer", int'(new_layer), nl);
    last_nl = int'(new_layer);
    @(posedge clock);
    #1;
    m_row = nxt;
`ifdef ROW_INDEX_SEQUENCER_LAYER_COUNT_EN
    if (c) m_lay = 0;
    else if (nl) m_lay = (m_lay + 1) % L;
`endif
    chk("row_index", int'(row_index), m_row);
    chk("seq_err", int'(seq_err), err);
    chk("layer_index", int'(layer_index), m_lay);
    chk("last_layer", int'(last_layer), exp_last());
  endtask
  task automatic add(input logic c, e, nr, nv, nq, input int qs, row, err, nl);
    vec_t v;
    v.c = c; v.e = e; v.nr = nr; v.nv = nv; v.nq = nq; v.qs = qs; v.row = row; v.err = err; v.nl = nl;
    tbl.push_back(v);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_row = 0;
    m_lay = 0;
    chk("reset_row", int'(row_index), 0);
    chk("reset_err", int'(seq_err), 0);
    chk("reset_layer", int'(layer_index), 0);
    chk("reset_last", int'(last_layer), (L == 1) ? 1 : 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
    clear = 0; en = 0; new_row = 0; new_vector = 0; new_quadrant_row = 0; quadrant_sel = '0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    do_reset();
    add(1, 0, 0, 0, 0, 1, 6, 0, 0);
    for (int i = 7; i <= 11; i++) add(0, 1, 1, 0, 0, 1, i, 0, 0);
    add(0, 1, 0, 0, 1, 1, 6, 0, 1);
    for (int i = 7; i <= 9; i++) add(0, 1, 1, 0, 0, 1, i, 0, 0);
    add(0, 1, 0, 1, 0, 1, 7, 0, 0);
    add(0, 1, 0, 1, 0, 1, 6, 1, 0);
    add(0, 1, 0, 1, 0, 1, 6, 1, 0);
    for (int i = 7; i <= 11; i++) add(0, 1, 1, 0, 0, 1, i, 0, 0);
    add(0, 1, 1, 0, 0, 1, 11, 1, 0);
    add(0, 0, 1, 0, 0, 1, 11, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 1, 1, 0, 0, 0, i, 0, 0);
    add(0, 1, 0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 2, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].e, tbl[i].nr, tbl[i].nv, tbl[i].nq, tbl[i].qs);
      chk("tbl_row", int'(row_index), tbl[i].row);
      chk("tbl_err", int'(seq_err), tbl[i].err);
      chk("tbl_new_layer", last_nl, tbl[i].nl);
    end
    step(1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < R; j++) step(0, 1, 0, 0, 1, 0);
`ifdef ROW_INDEX_SEQUENCER_LAYER_COUNT_EN
      chk("layer_seq", int'(layer_index), k % L);
      chk("last_seq", int'(last_layer), (k % L == L - 1) ? 1 : 0);
`else
      chk("layer_tied", int'(layer_index), 0);
      chk("last_tied", int'(last_layer), 0);
`endif
    end
    for (int j = 0; j < R - 1; j++) step(0, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1);
    chk("clear_over_layer", int'(layer_index), 0);
    chk("clear_row", int'(row_index), 6);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    #2;
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    chk("post_reset_row", int'(row_index), 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) < 5, $urandom_range(99) < 80, $urandom_range(99) < 40,
           $urandom_range(99) < 15, $urandom_range(99) < 15, int'($urandom_range((1 << QSEL_W) - 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
